// File: rtl/mem_map_pkg.sv
// Memory-map constants shared by the data-side responder and anything that
// needs to know where the I/O page lives (core test programs, the bench).
package mem_map_pkg;

  // Data RAM starts at byte address 0; its size is set by the RAM_WORDS
  // parameter of the responder.
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;

  // I/O page, word-aligned registers.
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FF04;
  localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_FF08;
  localparam logic [31:0] LED_ADDR    = 32'hFFFF_FF0C;

  // STATUS register layout.
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;   // count occupies [15:8]

  // Word-granular address compare: the byte offset bits are don't-care.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Data-port bus between the core memory stage and the responder, plus the
// TX byte stream towards the external sink.
//   master : core/sink side  (drives mem_write, addr, write_data, tx_ready)
//   slave  : responder side  (drives read_data, tx_valid, tx_data)
interface mem_responder_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output mem_write, addr, write_data, tx_ready,
    input  read_data, tx_valid, tx_data
  );

  modport slave (
    input  mem_write, addr, write_data, tx_ready,
    output read_data, tx_valid, tx_data
  );
endinterface

// File: rtl/tx_fifo.sv
// Show-ahead byte FIFO for the TX path.
//   push/push_data : enqueue request (accepted when not full, or full with a
//                    concurrent pop)
//   pop            : dequeue the head (ignored when empty)
//   empty/full/count, head (0 when empty)
//   overflow_set   : pulse when a push is dropped because the FIFO is full
// Synchronous active-high reset empties the FIFO; storage is not cleared.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head,
  output logic                     overflow_set
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // When full, a concurrent pop frees the slot wptr points at, so the
  // push can land there in the same edge.
  assign do_pop       = pop && !empty;
  assign do_push      = push && (!full || do_pop);
  assign overflow_set = push && full && !do_pop;

  assign head = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Data-side memory responder for the pipelined MIPS core: word RAM plus an
// I/O page (TX FIFO, free-running cycle counter, LED register).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : core data port (mem_write/addr/write_data -> read_data,
//                  combinational) and TX stream (tx_valid/tx_data/tx_ready)
//   led_o        : LED register
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_responder_if.slave    bus,
  output logic [15:0]       led_o
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // ---------------- decode ----------------
  logic [29:0]       word_off;
  logic              hit_ram, hit_tx, hit_status, hit_cycles, hit_led;
  logic [RAM_AW-1:0] ram_idx;

  assign word_off   = bus.addr[31:2] - RAM_BASE[31:2];
  assign hit_ram    = (word_off[29:RAM_AW] == '0);
  assign ram_idx    = word_off[RAM_AW-1:0];
  assign hit_tx     = word_match(bus.addr, TXDATA_ADDR);
  assign hit_status = word_match(bus.addr, STATUS_ADDR);
  assign hit_cycles = word_match(bus.addr, CYCLES_ADDR);
  assign hit_led    = word_match(bus.addr, LED_ADDR);

  // ---------------- RAM ----------------
  // Not reset; async read returns pre-edge contents during a write.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk_i) begin
    if (bus.mem_write && hit_ram) ram[ram_idx] <= bus.write_data;
  end

  // ---------------- cycle counter ----------------
  logic [31:0] cycles;

  always_ff @(posedge clk_i) begin
    if (rst_i)                           cycles <= '0;
    else if (bus.mem_write && hit_cycles) cycles <= bus.write_data;
    else                                 cycles <= cycles + 32'd1;
  end

  // ---------------- LED ----------------
  logic [15:0] led_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                         led_q <= '0;
    else if (bus.mem_write && hit_led) led_q <= bus.write_data[15:0];
  end

  assign led_o = led_q;

  // ---------------- TX FIFO ----------------
  logic             f_empty, f_full, f_ovf_set;
  logic [CNT_W-1:0] f_count;
  logic [7:0]       f_head;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk          (clk_i),
    .rst          (rst_i),
    .push         (bus.mem_write && hit_tx),
    .push_data    (bus.write_data[7:0]),
    .pop          (bus.tx_valid && bus.tx_ready),
    .empty        (f_empty),
    .full         (f_full),
    .count        (f_count),
    .head         (f_head),
    .overflow_set (f_ovf_set)
  );

  assign bus.tx_valid = !f_empty;
  assign bus.tx_data  = f_head;

  // Sticky overflow; a drop in the same cycle as a clear wins.
  logic overflow;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                                overflow <= 1'b0;
    else if (f_ovf_set)                                       overflow <= 1'b1;
    else if (bus.mem_write && hit_status && bus.write_data[2]) overflow <= 1'b0;
  end

  // ---------------- read mux ----------------
  logic [31:0] status_word;

  always_comb begin
    status_word                        = '0;
    status_word[STAT_EMPTY_BIT]        = f_empty;
    status_word[STAT_FULL_BIT]         = f_full;
    status_word[STAT_OVF_BIT]          = overflow;
    status_word[STAT_COUNT_LSB +: 8]   = 8'(f_count);
  end

  // TXDATA and unmapped addresses fall through to 0.
  always_comb begin
    bus.read_data = '0;
    if (hit_ram)         bus.read_data = ram[ram_idx];
    else if (hit_status) bus.read_data = status_word;
    else if (hit_cycles) bus.read_data = cycles;
    else if (hit_led)    bus.read_data = {16'h0, led_q};
  end

endmodule
